// File: rtl/cordic_sched_pkg.sv
// rtl/cordic_sched_pkg.sv - shared types and default sizes for the CORDIC scheduler
package cordic_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DW         = 32;
    localparam int DEF_CORDIC_LAT = 32;

endpackage

// File: rtl/cordic_sched_if.sv
// rtl/cordic_sched_if.sv - requester and response handshake bundle of the CORDIC scheduler
interface cordic_sched_if
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DEF_DW,
    parameter int IDW   = $clog2(N_REQ)
);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_x;
    logic [N_REQ*DW-1:0] req_y;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_phase;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_phase
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_phase
    );

endinterface

// File: rtl/cordic_sched_rr_arbiter.sv
// rtl/cordic_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int idx;

    // Walk ptr, ptr+1, ... modulo N; the first active request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - round-robin sharing of one handshake-less serial CORDIC
// between N_REQ requesters; operands are held for CORDIC_LAT edges, then the phase is returned.
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DW         = DEF_DW,
    parameter int CORDIC_LAT = DEF_CORDIC_LAT,
    parameter int IDW        = $clog2(N_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    cordic_sched_if.slave bus,
    output logic [DW-1:0] cor_x,
    output logic [DW-1:0] cor_y,
    input  logic [DW-1:0] cor_phase,
    output logic          busy
);

    localparam int CW = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is masked while rst is high so nothing looks accepted during reset.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = WAIT;
                    if (!rst) begin
                        bus.req_ready = grant;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            cnt           <= '0;
            cor_x         <= '0;
            cor_y         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_phase <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cor_x      <= bus.req_x[int'(grant_idx)*DW +: DW];
                        cor_y      <= bus.req_y[int'(grant_idx)*DW +: DW];
                        bus.rsp_id <= grant_idx;
                        cnt        <= CW'(CORDIC_LAT - 1);
                    end
                end
                WAIT: begin
                    // cnt reaches zero CORDIC_LAT-1 edges after the load; the next edge samples.
                    if (cnt == '0) begin
                        bus.rsp_phase <= cor_phase;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        rr_ptr        <= (bus.rsp_id == IDW'(N_REQ - 1)) ? '0 : bus.rsp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));

endmodule

// File: tb/tb_cordic_sched.sv
// tb/tb_cordic_sched.sv - self-checking bench for cordic_sched with a latency-aware CORDIC stub
module tb_cordic_sched;
    import cordic_sched_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int L   = 32;
    localparam int IDW = 2;

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*DW-1:0] x;
        logic [N*DW-1:0] y;
        int              exp_id;
        logic [DW-1:0]   exp_phase;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cor_x;
    logic [DW-1:0] cor_y;
    logic [DW-1:0] cor_phase;
    logic          busy;

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   model_ptr = 0;
    vec_t tbl [9];

    cordic_sched_if #(.N_REQ(N), .DW(DW), .IDW(IDW)) bus ();

    cordic_sched #(
        .N_REQ      (N),
        .DW         (DW),
        .CORDIC_LAT (L),
        .IDW        (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cor_x     (cor_x),
        .cor_y     (cor_y),
        .cor_phase (cor_phase),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // CORDIC stand-in: a result appears only once the operands have been stable long enough.
    logic [DW-1:0] prev_x = '0;
    logic [DW-1:0] prev_y = '0;
    int            stab   = 0;
    always @(negedge clk) begin
        if (cor_x != prev_x || cor_y != prev_y) begin
            stab   <= 0;
            prev_x <= cor_x;
            prev_y <= cor_y;
        end else if (stab < 1000) begin
            stab <= stab + 1;
        end
    end
    assign cor_phase = (cor_x == prev_x && cor_y == prev_y && stab >= L - 1) ? cor_x - cor_y : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] opx(input int i);
        return bus.req_x[i*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] opy(input int i);
        return bus.req_y[i*DW +: DW];
    endfunction

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return 0;
    endfunction

    // One full operation: grant, CORDIC wait, response with bp stalled cycles, handshake.
    task automatic run_op(input int exp_id, input int bp, output int waited);
        int            t;
        logic [DW-1:0] exp_ph;
        logic [DW-1:0] ex;
        logic [DW-1:0] ey;
        #1;
        t = 0;
        while (bus.req_ready == '0 && t < 4*L) begin
            tick();
            t++;
        end
        waited = t;
        chk("grant", DW'(bus.req_ready), DW'(1 << exp_id));
        ex     = opx(exp_id);
        ey     = opy(exp_id);
        exp_ph = ex - ey;
        tick();
        chk("busy_wait", DW'(busy), 1);
        chk("ready_wait", DW'(bus.req_ready), 0);
        t = 1;
        while (!bus.rsp_valid && t < 4*L) begin
            tick();
            t++;
        end
        chk("latency", t, L + 1);
        chk("rsp_id", DW'(bus.rsp_id), exp_id);
        chk("rsp_phase", bus.rsp_phase, exp_ph);
        chk("cor_x", cor_x, ex);
        chk("cor_y", cor_y, ey);
        if (bp > 0) begin
            bus.rsp_ready = 1'b0;
            for (int i = 0; i < bp; i++) begin
                tick();
                chk("bp_valid", DW'(bus.rsp_valid), 1);
                chk("bp_id", DW'(bus.rsp_id), exp_id);
                chk("bp_phase", bus.rsp_phase, exp_ph);
                chk("bp_ready", DW'(bus.req_ready), 0);
            end
            bus.rsp_ready = 1'b1;
        end
        tick();
        chk("rsp_done", DW'(bus.rsp_valid), 0);
        chk("cor_x_kept", cor_x, ex);
        model_ptr = (exp_id + 1) % N;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        int           w;
        logic [N-1:0] v;

        tbl[0] = '{4'b0001, {96'd0, 32'd1000000}, {96'd0, 32'd1000000}, 0, 32'd0};
        tbl[1] = '{4'b0001, {96'd0, 32'hFFFFFFFB}, {96'd0, 32'd7}, 0, 32'hFFFFFFF4};
        tbl[2] = '{4'b1111, {32'd300, 32'd200, 32'd100, 32'd0}, 128'd0, 1, 32'd100};
        tbl[3] = '{4'b1111, {32'd300, 32'd200, 32'd100, 32'd0}, 128'd0, 2, 32'd200};
        tbl[4] = '{4'b1001, {32'd300, 32'd200, 32'd100, 32'd0}, 128'd0, 3, 32'd300};
        tbl[5] = '{4'b1001, {32'd300, 32'd200, 32'd100, 32'd0}, 128'd0, 0, 32'd0};
        tbl[6] = '{4'b0010, 128'd0, {64'd0, 32'hFFF0BDC0, 32'd0}, 1, 32'd1000000};
        tbl[7] = '{4'b0101, {32'd0, 32'd7, 32'd0, 32'd50}, {32'd0, 32'd9, 32'd0, 32'd20}, 2, 32'hFFFFFFFE};
        tbl[8] = '{4'b0101, {32'd0, 32'd7, 32'd0, 32'd50}, {32'd0, 32'd9, 32'd0, 32'd20}, 0, 32'd30};

        bus.req_valid = 4'b1111;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b1;
        rst           = 1'b1;
        tick();
        tick();
        chk("reset_ready", DW'(bus.req_ready), 0);
        chk("reset_busy", DW'(busy), 0);
        chk("reset_valid", DW'(bus.rsp_valid), 0);
        chk("reset_id", DW'(bus.rsp_id), 0);
        chk("reset_phase", bus.rsp_phase, 0);
        chk("reset_cor_x", cor_x, 0);
        chk("reset_cor_y", cor_y, 0);
        bus.req_valid = '0;
        rst           = 1'b0;
        model_ptr     = 0;
        tick();

        for (int i = 0; i < 9; i++) begin
            bus.req_valid = tbl[i].valid;
            bus.req_x     = tbl[i].x;
            bus.req_y     = tbl[i].y;
            run_op(tbl[i].exp_id, 0, w);
            chk("tbl_phase", bus.rsp_phase, tbl[i].exp_phase);
        end

        // Reset in the middle of WAIT with a non-zero round-robin pointer.
        bus.req_valid = 4'b0010;
        bus.req_x     = {32'd0, 32'd0, 32'd11, 32'd0};
        bus.req_y     = '0;
        run_op(1, 0, w);
        bus.req_valid = 4'b0100;
        bus.req_x[2*DW +: DW] = 32'd77;
        #1;
        chk("mid_grant", DW'(bus.req_ready), 32'h4);
        tick();
        repeat (L - 1 - 10) tick();
        chk("mid_busy", DW'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", DW'(busy), 0);
        chk("mid_rst_valid", DW'(bus.rsp_valid), 0);
        chk("mid_rst_id", DW'(bus.rsp_id), 0);
        chk("mid_rst_phase", bus.rsp_phase, 0);
        chk("mid_rst_cor_x", cor_x, 0);
        chk("mid_rst_cor_y", cor_y, 0);
        bus.req_valid = 4'b0110;
        #1;
        chk("mid_rst_ready", DW'(bus.req_ready), 0);
        tick();
        tick();
        chk("mid_rst_novalid", DW'(bus.rsp_valid), 0);
        rst       = 1'b0;
        model_ptr = 0;
        run_op(1, 0, w);
        chk("post_rst_gap", w, 0);

        // Held simultaneous requests: 0,1,2,3,0 back to back.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        model_ptr = 0;
        bus.req_valid = 4'b1111;
        bus.req_x     = {32'd300, 32'd200, 32'd100, 32'd0};
        bus.req_y     = '0;
        for (int k = 0; k < 5; k++) begin
            run_op(k % 4, 0, w);
            if (k > 0) chk("period", w, 0);
        end

        // Backpressure: ten stalled RESP cycles, then the next grant follows the handshake.
        run_op(1, 10, w);
        run_op(2, 0, w);
        chk("bp_next_gap", w, 0);

        for (int n = 0; n < 30; n++) begin
            v = N'($urandom_range(0, 15));
            if (v == '0) v = N'(1 << $urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                bus.req_x[i*DW +: DW] = $urandom;
                bus.req_y[i*DW +: DW] = $urandom;
            end
            bus.req_valid = v;
            run_op(model_grant(v), int'($urandom_range(0, 3)), w);
            chk("rnd_gap", w, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
